// File: rtl/ins_cache.sv
// rtl/ins_cache.sv - direct-mapped read-only instruction cache with block fill from ins_memory
module ins_cache #(
    parameter int INDEX_BITS = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 read,
    input  logic [9:0]           address,
    output logic [31:0]          readinst,
    output logic                 busywait,
    output logic                 mem_read,
    output logic [5:0]           mem_address,
    input  logic [127:0]         mem_readdata,
    input  logic                 mem_busywait,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int TAG_BITS = 6 - INDEX_BITS;
    localparam int LINES    = 2 ** INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            miss_addr_q, miss_addr_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [127:0]          data_q [LINES];

    logic [TAG_BITS-1:0]   addr_tag;
    logic [INDEX_BITS-1:0] addr_idx;
    logic [1:0]            addr_word;
    logic [TAG_BITS-1:0]   miss_tag;
    logic [INDEX_BITS-1:0] miss_idx;
    logic                  hit;
    logic                  fill_en;
    logic                  busy_c;
    logic                  unused_addr_bits;

    assign addr_tag         = address[9:4+INDEX_BITS];
    assign addr_idx         = address[3+INDEX_BITS:4];
    assign addr_word        = address[3:2];
    assign unused_addr_bits = ^address[1:0];
    assign miss_tag         = miss_addr_q[5:INDEX_BITS];
    assign miss_idx         = miss_addr_q[INDEX_BITS-1:0];

    // Combinational lookup and word select from the indexed line
    always_comb begin
        hit      = read & valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
        readinst = data_q[addr_idx][32*addr_word +: 32];
    end

    // Next-state, handshake outputs and saturating counter updates
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        busy_c      = 1'b0;
        mem_read    = 1'b0;
        mem_address = 6'd0;
        fill_en     = 1'b0;
        case (state_q)
            IDLE: begin
                busy_c = read & ~hit;
                if (read & ~hit) begin
                    state_d     = MEM_READ;
                    miss_addr_d = {addr_tag, addr_idx};
                    if (miss_cnt_q != {CNT_WIDTH{1'b1}})
                        miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                end else if (hit) begin
                    if (hit_cnt_q != {CNT_WIDTH{1'b1}})
                        hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                end
            end
            MEM_READ: begin
                busy_c      = 1'b1;
                mem_read    = 1'b1;
                mem_address = miss_addr_q;
                if (!mem_busywait)
                    state_d = UPDATE;
            end
            UPDATE: begin
                busy_c            = 1'b1;
                fill_en           = 1'b1;
                valid_d[miss_idx] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Stall is held low while reset is asserted even if a read is pending
        busywait = busy_c & ~reset;
    end

    // Control state, valid bits and counters; cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            miss_addr_q <= 6'd0;
            valid_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag and data arrays are written only on a fill and never cleared
    always_ff @(posedge clock) begin
        if (fill_en) begin
            data_q[miss_idx] <= mem_readdata;
            tag_q[miss_idx]  <= miss_tag;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_ins_cache.sv
// tb/tb_ins_cache.sv - directed self-checking bench for ins_cache
module tb_ins_cache;

    logic         clock;
    logic         reset;
    logic         read;
    logic [9:0]   address;
    logic [31:0]  readinst;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    int checks = 0;
    int errors = 0;

    ins_cache #(.INDEX_BITS(3), .CNT_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .readinst     (readinst),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ins_memory model: two busy cycles per request, block held after the request drops
    int         wcnt;
    logic [5:0] blk;

    function automatic logic [31:0] mem_word(input logic [5:0] b, input int w);
        logic [31:0] r;
        if (b == 6'd0) begin
            case (w)
                0:       r = 32'h0000_0009;
                1:       r = 32'h0001_0023;
                2:       r = 32'hDEAD_0002;
                default: r = 32'h0303_0201;
            endcase
        end else begin
            r = 32'hB000_0000 | {18'd0, b, 8'd0} | 32'(w);
        end
        return r;
    endfunction

    always @(posedge clock) begin
        if (!mem_read) wcnt <= 0;
        else begin
            wcnt <= wcnt + 1;
            blk  <= mem_address;
        end
    end

    assign mem_busywait = mem_read && (wcnt < 2);
    assign mem_readdata = {mem_word(blk, 3), mem_word(blk, 2), mem_word(blk, 1), mem_word(blk, 0)};

    task automatic wait_not_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!busywait) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; read = 1'b0; address = 10'h000;
        @(negedge clock);
        checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait got %b exp 0", busywait); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b exp 0", mem_read); end
        checks++; if (mem_address !== 6'h00) begin errors++; $display("FAIL reset_mem_address got %h exp 00", mem_address); end
        checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", hit_count, miss_count); end
        reset = 1'b0;
    endtask

    task automatic test_miss_fill;
        bit ok;
        read = 1'b1; address = 10'h000;
        #1;
        checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL miss_busywait got %b exp 1", busywait); end
        @(negedge clock);
        checks++; if (mem_read !== 1'b1 || mem_address !== 6'h00) begin errors++; $display("FAIL miss_mem_req got %b/%h exp 1/00", mem_read, mem_address); end
        checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL miss_count1 got %0d exp 1", miss_count); end
        wait_not_busy(ok);
        checks++; if (!ok) begin errors++; $display("FAIL miss_fill_timeout got busy exp idle"); end
        checks++; if (readinst !== 32'h0000_0009) begin errors++; $display("FAIL miss_readinst got %h exp 00000009", readinst); end
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL miss_hit_count got %0d exp 0", hit_count); end
    endtask

    task automatic test_hits;
        address = 10'h004;
        #1;
        checks++; if (busywait !== 1'b0 || readinst !== 32'h0001_0023) begin errors++; $display("FAIL hit_w1 got %b/%h exp 0/00010023", busywait, readinst); end
        @(negedge clock);
        checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL hit_count1 got %0d exp 1", hit_count); end
        address = 10'h00C;
        #1;
        checks++; if (busywait !== 1'b0 || readinst !== 32'h0303_0201) begin errors++; $display("FAIL hit_w3 got %b/%h exp 0/03030201", busywait, readinst); end
        @(negedge clock);
        checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL hit_count2 got %0d exp 2", hit_count); end
        read = 1'b0;
        @(negedge clock);
        checks++; if (busywait !== 1'b0 || hit_count !== 16'd2 || miss_count !== 16'd1) begin errors++; $display("FAIL idle_noread got %b/%0d/%0d exp 0/2/1", busywait, hit_count, miss_count); end
    endtask

    task automatic test_conflict;
        bit ok;
        read = 1'b1; address = 10'h080;
        #1;
        checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL conflict_a_busy got %b exp 1", busywait); end
        @(negedge clock);
        checks++; if (mem_address !== 6'h08 || miss_count !== 16'd2) begin errors++; $display("FAIL conflict_a_req got %h/%0d exp 08/2", mem_address, miss_count); end
        wait_not_busy(ok);
        checks++; if (!ok || readinst !== 32'hB000_0800) begin errors++; $display("FAIL conflict_a_data got %b/%h exp 1/b0000800", ok, readinst); end
        address = 10'h000;
        #1;
        checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL conflict_b_busy got %b exp 1", busywait); end
        @(negedge clock);
        checks++; if (mem_address !== 6'h00 || miss_count !== 16'd3) begin errors++; $display("FAIL conflict_b_req got %h/%0d exp 00/3", mem_address, miss_count); end
        wait_not_busy(ok);
        checks++; if (!ok || readinst !== 32'h0000_0009) begin errors++; $display("FAIL conflict_b_data got %b/%h exp 1/00000009", ok, readinst); end
    endtask

    task automatic test_redirect;
        bit ok;
        address = 10'h020;
        @(negedge clock);
        checks++; if (mem_read !== 1'b1 || mem_address !== 6'h02) begin errors++; $display("FAIL redir_req got %b/%h exp 1/02", mem_read, mem_address); end
        address = 10'h010;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!mem_read) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL redir_update_timeout got mem_read 1 exp 0"); end
        @(negedge clock);
        checks++; if (busywait !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL redir_second_miss got %b/%b exp 1/0", busywait, mem_read); end
        @(negedge clock);
        checks++; if (mem_address !== 6'h01 || miss_count !== 16'd5) begin errors++; $display("FAIL redir_second_req got %h/%0d exp 01/5", mem_address, miss_count); end
        wait_not_busy(ok);
        checks++; if (!ok || readinst !== 32'hB000_0100) begin errors++; $display("FAIL redir_second_data got %b/%h exp 1/b0000100", ok, readinst); end
        address = 10'h020;
        #1;
        checks++; if (busywait !== 1'b0 || readinst !== 32'hB000_0200) begin errors++; $display("FAIL redir_fill_idx2 got %b/%h exp 0/b0000200", busywait, readinst); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        address = 10'h030;
        @(negedge clock);
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_pre_mem_read got %b exp 1", mem_read); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b0 || busywait !== 1'b0) begin errors++; $display("FAIL rst_async_outputs got %b/%b exp 0/0", mem_read, busywait); end
        checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL rst_async_counts got %0d/%0d exp 0/0", hit_count, miss_count); end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        address = 10'h000;
        #1;
        checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL rst_remiss_busy got %b exp 1", busywait); end
        @(negedge clock);
        checks++; if (mem_read !== 1'b1 || mem_address !== 6'h00 || miss_count !== 16'd1) begin errors++; $display("FAIL rst_remiss_req got %b/%h/%0d exp 1/00/1", mem_read, mem_address, miss_count); end
        wait_not_busy(ok);
        checks++; if (!ok || readinst !== 32'h0000_0009) begin errors++; $display("FAIL rst_remiss_data got %b/%h exp 1/00000009", ok, readinst); end
    endtask

    task automatic test_saturation;
        repeat (65539) @(negedge clock);
        checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hit_count got %h exp ffff", hit_count); end
        checks++; if (miss_count !== 16'd1 || busywait !== 1'b0) begin errors++; $display("FAIL sat_other got %0d/%b exp 1/0", miss_count, busywait); end
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hits();
        test_conflict();
        test_redirect();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
